// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding, default geometry and width helpers for the convolution sequencer
package conv_pkg;
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;
   function automatic int clog2w(input int n);
      return n <= 1 ? 1 : $clog2(n);
   endfunction
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_KERNEL     = 3;
   localparam int DEF_IMG_W      = 8;
   localparam int DEF_IMG_H      = 8;
   localparam int DEF_ADDR_W     = 8;
   localparam int DEF_N          = DEF_KERNEL * DEF_KERNEL;
   localparam int DEF_OW         = DEF_IMG_W - DEF_KERNEL + 1;
   localparam int DEF_OH         = DEF_IMG_H - DEF_KERNEL + 1;
   localparam int DEF_WA_W       = clog2w(DEF_N);
endpackage

// File: rtl/conv_mac_ctrl_if.sv
// conv_mac_ctrl_if: memory, MAC and output-stream signals between the sequencer and its datapath
interface conv_mac_ctrl_if #(
   parameter int DATA_WIDTH = conv_pkg::DEF_DATA_WIDTH,
   parameter int ADDR_W     = conv_pkg::DEF_ADDR_W,
   parameter int WA_W       = conv_pkg::DEF_WA_W
);
   logic                  mem_rd_en;
   logic [ADDR_W-1:0]     data_addr;
   logic [WA_W-1:0]       weight_addr;
   logic                  mac_en;
   logic                  mac_bias_sel;
   logic [DATA_WIDTH-1:0] mac_result_i;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_W-1:0]     out_addr;
   modport master (
      output mem_rd_en, data_addr, weight_addr, mac_en, mac_bias_sel, out_valid, out_data, out_addr,
      input  mac_result_i, out_ready
   );
   modport slave (
      input  mem_rd_en, data_addr, weight_addr, mac_en, mac_bias_sel, out_valid, out_data, out_addr,
      output mac_result_i, out_ready
   );
endinterface

// File: rtl/conv_win_cnt.sv
// conv_win_cnt: nested tap/pixel counters with incrementally maintained feature, weight and output addresses
module conv_win_cnt
   import conv_pkg::*;
#(
   parameter int KERNEL = DEF_KERNEL,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int WA_W   = DEF_WA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              tap_step,
   input  logic              pix_step,
   output logic [ADDR_W-1:0] data_addr,
   output logic [WA_W-1:0]   weight_addr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              last_tap,
   output logic              last_pix
);
   localparam int OW = IMG_W - KERNEL + 1;
   localparam int OH = IMG_H - KERNEL + 1;
   localparam int KW = clog2w(KERNEL);
   localparam int XW = clog2w(OW);
   localparam int YW = clog2w(OH);
   logic [KW-1:0]     kx, ky;
   logic [XW-1:0]     ox;
   logic [YW-1:0]     oy;
   logic [ADDR_W-1:0] tap_off, pix_base;
   logic              kx_wrap, ox_wrap;
   assign kx_wrap     = kx == KW'(KERNEL - 1);
   assign ox_wrap     = ox == XW'(OW - 1);
   assign last_tap    = kx_wrap && ky == KW'(KERNEL - 1);
   assign last_pix    = ox_wrap && oy == YW'(OH - 1);
   assign data_addr   = pix_base + tap_off;
   // Row wraps skip the columns the window did not cover: +OW for taps, +K for pixels
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n || clr) begin
         kx <= '0; ky <= '0; ox <= '0; oy <= '0;
         tap_off <= '0; pix_base <= '0; weight_addr <= '0; out_addr <= '0;
      end else begin
         if (tap_step) begin
            kx          <= kx_wrap ? '0 : kx + 1'b1;
            ky          <= last_tap ? '0 : kx_wrap ? ky + 1'b1 : ky;
            tap_off     <= last_tap ? '0 : kx_wrap ? tap_off + ADDR_W'(OW) : tap_off + 1'b1;
            weight_addr <= last_tap ? '0 : weight_addr + 1'b1;
         end
         if (pix_step) begin
            ox       <= ox_wrap ? '0 : ox + 1'b1;
            oy       <= ox_wrap ? oy + 1'b1 : oy;
            pix_base <= ox_wrap ? pix_base + ADDR_W'(KERNEL) : pix_base + 1'b1;
            out_addr <= out_addr + 1'b1;
         end
      end
endmodule

// File: rtl/conv_mac_ctrl.sv
// conv_mac_ctrl: sequences K x K window taps through a single MAC and streams each finished output pixel
module conv_mac_ctrl
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int KERNEL     = DEF_KERNEL,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int ADDR_W     = DEF_ADDR_W
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   conv_mac_ctrl_if.master bus
);
   localparam int WA_W = clog2w(KERNEL * KERNEL);
   state_t            state, nxt;
   logic              last_tap, last_pix, hs, mac_en_q, bias_q;
   logic [ADDR_W-1:0] data_addr, out_addr;
   logic [WA_W-1:0]   weight_addr;
   conv_win_cnt #(
      .KERNEL(KERNEL), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .WA_W(WA_W)
   ) u_cnt (
      .clk, .rst_n,
      .clr(state == DONE),
      .tap_step(state == RUN),
      .pix_step(hs && !last_pix),
      .data_addr, .weight_addr, .out_addr, .last_tap, .last_pix
   );
   // Read data arrives one cycle after the strobe, so MAC controls trail it by one register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         mac_en_q <= 1'b0;
         bias_q   <= 1'b0;
      end else begin
         state    <= nxt;
         mac_en_q <= state == RUN;
         bias_q   <= state == RUN && weight_addr != '0;
      end
   always_comb begin
      hs  = state == OUT && bus.out_ready;
      nxt = state == IDLE  ? (start ? RUN : IDLE) :
            state == RUN   ? (last_tap ? DRAIN : RUN) :
            state == DRAIN ? OUT :
            state == OUT   ? (!hs ? OUT : last_pix ? DONE : RUN) : IDLE;
      busy             = state == RUN || state == DRAIN || state == OUT;
      done             = state == DONE;
      bus.mem_rd_en    = state == RUN;
      bus.data_addr    = data_addr;
      bus.weight_addr  = weight_addr;
      bus.mac_en       = mac_en_q;
      bus.mac_bias_sel = bias_q;
      bus.out_valid    = state == OUT;
      bus.out_data     = state == OUT ? bus.mac_result_i : '0;
      bus.out_addr     = out_addr;
   end
endmodule

// File: tb/tb_conv_mac_ctrl.sv
// tb_conv_mac_ctrl: drives the sequencer with RAM/MAC models and checks outputs against a direct convolution model
module tb_conv_mac_ctrl;
   import conv_pkg::*;
   localparam int DW = 16, K = 3, W = 4, H = 4, AW = 8;
   localparam int N = K * K, OW = W - K + 1, OH = H - K + 1, P = OW * OH, WA = clog2w(N);
   typedef struct {
      logic v, r, rd, me, bs, busy, done;
      logic [DW-1:0] d;
      logic [AW-1:0] a, da;
      logic [WA-1:0] wa;
   } smp_t;
   logic clk = 0, rst_n = 0, start = 0, rdy = 1, busy, done;
   logic [DW-1:0] fmem [2**AW];
   logic [DW-1:0] wmem [2**WA];
   logic [DW-1:0] bias = '0, fq, wq, acc;
   int cyc = 0, n_tests = 0, n_fail = 0, dn;
   smp_t tr[$];
   logic [DW-1:0] od[$];
   logic [AW-1:0] oa[$];
   conv_mac_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .WA_W(WA)) bus ();
   conv_mac_ctrl #(.DATA_WIDTH(DW), .KERNEL(K), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   assign bus.out_ready    = rdy;
   assign bus.mac_result_i = acc;
   // 1-cycle-latency RAMs feeding a registered MAC
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fq <= '0; wq <= '0; acc <= '0;
      end else begin
         if (bus.mem_rd_en) begin
            fq <= fmem[bus.data_addr];
            wq <= wmem[bus.weight_addr];
         end
         if (bus.mac_en) acc <= (bus.mac_bias_sel ? acc : bias) + fq * wq;
      end

   function automatic logic [DW-1:0] exp_pix(input int p);
      logic [DW-1:0] s = bias;
      for (int ky = 0; ky < K; ky++)
         for (int kx = 0; kx < K; kx++)
            s = s + DW'(fmem[(p / OW + ky) * W + p % OW + kx] * wmem[ky * K + kx]);
      return s;
   endfunction

   function automatic void collect();
      od.delete(); oa.delete(); dn = 0;
      foreach (tr[i]) begin
         if (tr[i].v && tr[i].r) begin od.push_back(tr[i].d); oa.push_back(tr[i].a); end
         if (tr[i].done) dn++;
      end
   endfunction

   task automatic fill(input int mode, input logic [DW-1:0] b);
      foreach (fmem[i]) fmem[i] = mode == 0 ? DW'(1) : mode == 1 ? DW'(i) : DW'($urandom_range(0, 255));
      foreach (wmem[i]) wmem[i] = mode == 2 ? DW'($urandom_range(0, 255)) : DW'(1);
      bias = b;
   endtask

   task automatic run_frame(input int stall, input bit rnd, input bit restart, output int lat, output bit to);
      int s, stall_left = stall;
      tr.delete(); to = 1; lat = 0;
      @(negedge clk); start = 1; s = cyc;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         start = restart && i == 3;
         rdy = rnd ? 1'($urandom_range(0, 1)) : !(stall_left > 0 && bus.out_valid);
         if (bus.out_valid && stall_left > 0) stall_left--;
         tr.push_back('{v: bus.out_valid, r: rdy, rd: bus.mem_rd_en, me: bus.mac_en, bs: bus.mac_bias_sel,
                        busy: busy, done: done, d: bus.out_data, a: bus.out_addr, da: bus.data_addr,
                        wa: bus.weight_addr});
         if (done) begin lat = cyc - s; to = 0; break; end
      end
      start = 0; rdy = 1;
   endtask

   task automatic test_reset;
      rst_n = 0;
      @(negedge clk);
      n_tests++;
      if ({busy, done, bus.mem_rd_en, bus.mac_en, bus.mac_bias_sel, bus.out_valid} !== '0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, bus.mem_rd_en, bus.mac_en, bus.mac_bias_sel, bus.out_valid});
      end
      n_tests++;
      if ({bus.data_addr, bus.weight_addr, bus.out_addr, bus.out_data} !== '0) begin
         n_fail++; $display("FAIL reset_data: da=%0d wa=%0d oa=%0d od=%0d expected all 0", bus.data_addr, bus.weight_addr, bus.out_addr, bus.out_data);
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_ones;
      int lat; bit to;
      fill(0, 0);
      run_frame(0, 0, 0, lat, to);
      collect();
      n_tests++; if (to) begin n_fail++; $display("FAIL ones_timeout: done never seen, required within 2000 cycles"); end
      n_tests++; if (lat !== 45) begin n_fail++; $display("FAIL ones_latency: got %0d expected 45", lat); end
      n_tests++; if (od.size() !== P) begin n_fail++; $display("FAIL ones_count: got %0d expected %0d", od.size(), P); end
      foreach (od[k]) begin
         n_tests++;
         if (od[k] !== DW'(9) || oa[k] !== AW'(k)) begin
            n_fail++; $display("FAIL ones_out%0d: got data %0d addr %0d expected data 9 addr %0d", k, od[k], oa[k], k);
         end
      end
      n_tests++; if (dn !== 1) begin n_fail++; $display("FAIL ones_done: got %0d pulses expected 1", dn); end
      @(negedge clk);
      n_tests++;
      if ({busy, done, bus.out_valid} !== 3'b000) begin
         n_fail++; $display("FAIL ones_idle: got busy/done/valid %b expected 000", {busy, done, bus.out_valid});
      end
   endtask

   task automatic test_window;
      int lat, j = 0, m = 0; bit to;
      fill(1, 0);
      run_frame(0, 0, 0, lat, to);
      n_tests++; if (to) begin n_fail++; $display("FAIL win_timeout: done never seen, required within 2000 cycles"); end
      foreach (tr[i]) begin
         if (i > 0) begin
            n_tests++;
            if (tr[i].me !== tr[i-1].rd) begin n_fail++; $display("FAIL win_mac_en@%0d: got %b expected %b", i, tr[i].me, tr[i-1].rd); end
         end
         if (tr[i].rd) begin
            if (j / N == 3) begin
               n_tests++;
               if (tr[i].da !== AW'((1 + (j % N) / K) * W + 1 + (j % N) % K) || tr[i].wa !== WA'(j % N)) begin
                  n_fail++; $display("FAIL win_addr%0d: got da %0d wa %0d expected da %0d wa %0d", j % N, tr[i].da, tr[i].wa,
                                     (1 + (j % N) / K) * W + 1 + (j % N) % K, j % N);
               end
            end
            j++;
         end
         if (tr[i].me) begin
            n_tests++;
            if (tr[i].bs !== (m % N != 0)) begin n_fail++; $display("FAIL win_bias_sel%0d: got %b expected %b", m, tr[i].bs, m % N != 0); end
            m++;
         end
      end
      n_tests++; if (j !== P * N) begin n_fail++; $display("FAIL win_reads: got %0d expected %0d", j, P * N); end
   endtask

   task automatic test_bias;
      int lat; bit to;
      logic [DW-1:0] want [P] = '{47, 56, 83, 92};
      fill(1, 2);
      run_frame(0, 0, 0, lat, to);
      collect();
      n_tests++; if (od.size() !== P) begin n_fail++; $display("FAIL bias_count: got %0d expected %0d", od.size(), P); end
      foreach (od[k]) begin
         n_tests++;
         if (k < P && (od[k] !== want[k] || oa[k] !== AW'(k))) begin
            n_fail++; $display("FAIL bias_out%0d: got %0d@%0d expected %0d@%0d", k, od[k], oa[k], want[k], k);
         end
      end
   endtask

   task automatic test_stall;
      int lat, f = -1; bit to;
      fill(0, 0);
      run_frame(5, 0, 0, lat, to);
      collect();
      foreach (tr[i]) if (f < 0 && tr[i].v) f = i;
      n_tests++;
      if (f < 0 || f + 6 >= tr.size()) begin
         n_fail++; $display("FAIL stall_setup: first valid at %0d of %0d samples, expected room for 7", f, tr.size());
      end else begin
         for (int i = f; i < f + 5; i++) begin
            n_tests++;
            if ({tr[i].v, tr[i].rd, tr[i].me} !== 3'b100 || tr[i].d !== DW'(9) || tr[i].a !== '0) begin
               n_fail++; $display("FAIL stall_hold%0d: got v/rd/me %b data %0d addr %0d expected 100 9 0", i - f,
                                  {tr[i].v, tr[i].rd, tr[i].me}, tr[i].d, tr[i].a);
            end
         end
         n_tests++;
         if (!(tr[f+5].v && tr[f+5].r) || tr[f+6].rd !== 1'b1) begin
            n_fail++; $display("FAIL stall_resume: got hs %b next rd %b expected 1 1", tr[f+5].v && tr[f+5].r, tr[f+6].rd);
         end
      end
      n_tests++; if (lat !== 50) begin n_fail++; $display("FAIL stall_latency: got %0d expected 50", lat); end
      n_tests++; if (od.size() !== P) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", od.size(), P); end
   endtask

   task automatic test_restart;
      int lat; bit to;
      fill(0, 0);
      run_frame(0, 0, 1, lat, to);
      collect();
      n_tests++;
      if (od.size() !== P || dn !== 1 || lat !== 45) begin
         n_fail++; $display("FAIL restart: got %0d outputs %0d done latency %0d expected %0d 1 45", od.size(), dn, lat, P);
      end
   endtask

   task automatic test_abort;
      int hs = 0, lat; bit to;
      fill(0, 0);
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      for (int i = 0; i < 200 && hs < 2; i++) begin
         if (bus.out_valid && rdy) hs++;
         @(negedge clk);
      end
      @(negedge clk);
      n_tests++;
      if (hs !== 2 || {busy, bus.mem_rd_en, bus.mac_en} !== 3'b111) begin
         n_fail++; $display("FAIL abort_setup: got %0d handshakes busy/rd/me %b expected 2 111", hs, {busy, bus.mem_rd_en, bus.mac_en});
      end
      #2 rst_n = 0;
      #1;
      n_tests++;
      if ({busy, done, bus.mem_rd_en, bus.mac_en, bus.mac_bias_sel, bus.out_valid} !== '0) begin
         n_fail++; $display("FAIL abort_ctrl: got %b expected 000000", {busy, done, bus.mem_rd_en, bus.mac_en, bus.mac_bias_sel, bus.out_valid});
      end
      n_tests++;
      if ({bus.data_addr, bus.weight_addr, bus.out_addr, bus.out_data} !== '0) begin
         n_fail++; $display("FAIL abort_data: da=%0d wa=%0d oa=%0d od=%0d expected all 0", bus.data_addr, bus.weight_addr, bus.out_addr, bus.out_data);
      end
      @(negedge clk); rst_n = 1;
      run_frame(0, 0, 0, lat, to);
      collect();
      n_tests++; if (od.size() !== P || lat !== 45) begin n_fail++; $display("FAIL abort_rerun: got %0d outputs latency %0d expected %0d 45", od.size(), lat, P); end
      foreach (od[k]) begin
         n_tests++;
         if (od[k] !== DW'(9) || oa[k] !== AW'(k)) begin n_fail++; $display("FAIL abort_out%0d: got %0d@%0d expected 9@%0d", k, od[k], oa[k], k); end
      end
   endtask

   task automatic test_random;
      int lat; bit to;
      for (int r = 0; r < 3; r++) begin
         fill(2, DW'($urandom));
         run_frame(0, 1, 0, lat, to);
         collect();
         n_tests++; if (to || od.size() !== P) begin n_fail++; $display("FAIL rand%0d_count: got %0d outputs timeout %b expected %0d 0", r, od.size(), to, P); end
         foreach (od[k]) begin
            n_tests++;
            if (od[k] !== exp_pix(k) || oa[k] !== AW'(k)) begin
               n_fail++; $display("FAIL rand%0d_out%0d: got %0d@%0d expected %0d@%0d", r, k, od[k], oa[k], exp_pix(k), k);
            end
         end
         for (int i = 0; i + 1 < tr.size(); i++)
            if (tr[i].v && !tr[i].r) begin
               n_tests++;
               if (!tr[i+1].v || tr[i+1].d !== tr[i].d || tr[i+1].a !== tr[i].a) begin
                  n_fail++; $display("FAIL rand%0d_hold@%0d: got v %b %0d@%0d expected 1 %0d@%0d", r, i, tr[i+1].v, tr[i+1].d, tr[i+1].a, tr[i].d, tr[i].a);
               end
            end
      end
   endtask

   initial begin
      test_reset();
      test_ones();
      test_window();
      test_bias();
      test_stall();
      test_restart();
      test_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
